// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: instruction encoding and sequencer state types shared by
// the program-counter sequencer, its return stack and the surrounding ICU.
//   OPC_W        opcode width
//   PROG_ADDR_W  operand width of the default program word layout
//   instruction_t  ICU opcodes
//   seq_state_t    sequencer FSM states
//   prog_word_t    {opcode, operand} program memory word
package pc_sequencer_pkg;

  localparam int OPC_W       = 4;
  localparam int PROG_ADDR_W = 8;

  typedef enum logic [OPC_W-1:0] {
    NOPO = 4'h0,
    LD   = 4'h1,
    LDC  = 4'h2,
    AND  = 4'h3,
    ANDC = 4'h4,
    OR   = 4'h5,
    ORC  = 4'h6,
    XNOR = 4'h7,
    STO  = 4'h8,
    STOC = 4'h9,
    IEN  = 4'hA,
    OEN  = 4'hB,
    JMP  = 4'hC,
    RTN  = 4'hD,
    SKZ  = 4'hE,
    NOPF = 4'hF
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    ISSUE   = 3'd3,
    RELEASE = 3'd4,
    EVAL    = 3'd5,
    HALT    = 3'd6
  } seq_state_t;

  typedef struct packed {
    instruction_t               opcode;
    logic [PROG_ADDR_W-1:0]     operand;
  } prog_word_t;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: LIFO of return addresses for subroutine calls.
//   clk, rst       clock, synchronous active-high reset (empties the stack)
//   push, din      store din on top; ignored when full
//   pop            discard top entry; ignored when empty
//   dout           current top entry (don't care when empty)
//   empty, full    occupancy status
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    dout  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) dout = mem_q[i];
      if (push && !full && cnt_q == CW'(i)) mem_d[i] = din;
    end
    if (push && !full)       cnt_d = cnt_q + CW'(1);
    else if (pop && !empty)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Entry contents need no reset: the count alone defines what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch/issue stage in front of the ICU.
// Fetches {opcode, operand}, hands it to the ICU over a four-phase req/ack
// handshake, then picks the next PC from the ICU's jmp/rtn/flag_o/flag_f.
// Build option: PC_STACK_EN adds the return-address stack (JMP after a
// NOPO becomes a call, RTN pops); without it stack_ovf/stack_unf are 0.
//   clk, rst                    clock, synchronous active-high reset
//   run                         keep fetching; 0 parks in IDLE after the
//                               current instruction
//   mem_addr, mem_rd, mem_data  program memory (data one cycle after rd)
//   req, ack                    ICU handshake
//   instruction, io_addr        latched opcode/operand, stable while req=1
//   jmp, rtn, flag_o, flag_f    ICU result strobes, sampled in EVAL
//   pc, halted                  current PC, set by flag_f
//   stack_ovf, stack_unf        sticky stack error flags
//
// state   | meaning
// IDLE    | parked, waiting for run
// FETCH   | mem_rd asserted at pc
// LATCH   | program word captured into instruction/io_addr
// ISSUE   | req high until ack seen
// RELEASE | req low until ack drops
// EVAL    | ICU strobes choose the next pc
// HALT    | stopped by flag_f, only rst leaves
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd,
  input  logic [OPC_W+ADDR_W-1:0] mem_data,
  output logic                    req,
  input  logic                    ack,
  output instruction_t            instruction,
  output logic [ADDR_W-1:0]       io_addr,
  input  logic                    jmp,
  input  logic                    rtn,
  input  logic                    flag_o,
  input  logic                    flag_f,
  output logic [ADDR_W-1:0]       pc,
  output logic                    halted,
  output logic                    stack_ovf,
  output logic                    stack_unf
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  instruction_t      instr_q, instr_d;
  logic [ADDR_W-1:0] io_addr_q, io_addr_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef PC_STACK_EN
  logic              call_armed_q, call_armed_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              stk_push, stk_pop, stk_empty, stk_full;
  logic [ADDR_W-1:0] stk_dout;

  return_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_return_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
`else
  // Depth only sizes the stack; keep the parameter list identical in both builds.
  if (STACK_DEPTH < 1) begin : g_depth_unused
  end
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

  assign mem_addr    = pc_q;
  assign mem_rd      = (state_q == FETCH);
  assign req         = (state_q == ISSUE);
  assign instruction = instr_q;
  assign io_addr     = io_addr_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    io_addr_d = io_addr_q;
    halted_d  = halted_q;
`ifdef PC_STACK_EN
    call_armed_d = call_armed_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
`endif
    case (state_q)
      IDLE:    if (run) state_d = FETCH;
      FETCH:   state_d = LATCH;
      LATCH: begin
        instr_d   = instruction_t'(mem_data[ADDR_W +: OPC_W]);
        io_addr_d = mem_data[ADDR_W-1:0];
        state_d   = ISSUE;
      end
      ISSUE:   if (ack)  state_d = RELEASE;
      RELEASE: if (!ack) state_d = EVAL;
      EVAL: begin
        if (flag_f) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          if (rtn) begin
`ifdef PC_STACK_EN
            if (!stk_empty) begin
              stk_pop = 1'b1;
              pc_d    = stk_dout;
            end else begin
              unf_d = 1'b1;
              pc_d  = pc_inc;
            end
`else
            pc_d = pc_inc;
`endif
          end else if (jmp) begin
            pc_d = io_addr_q;
`ifdef PC_STACK_EN
            // A full stack drops the return address but the jump still goes.
            if (call_armed_q) begin
              if (stk_full) ovf_d    = 1'b1;
              else          stk_push = 1'b1;
            end
            call_armed_d = 1'b0;
`endif
          end else if (flag_o) begin
`ifdef PC_STACK_EN
            call_armed_d = 1'b1;
`endif
            pc_d = pc_inc;
          end else begin
            pc_d = pc_inc;
          end
          state_d = run ? FETCH : IDLE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= NOPO;
      io_addr_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      io_addr_q <= io_addr_d;
      halted_q  <= halted_d;
    end
  end

`ifdef PC_STACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      call_armed_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      call_armed_q <= call_armed_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end
`endif

endmodule
